// File: rtl/rst_seq_if.sv
// Handshake bundle between the clock-generator side and the reset sequencer:
// raw lock/button inputs in, staged resets and debug count out.
interface rst_seq_if;
  logic       locked;
  logic       btn;
  logic       periph_rst;
  logic       core_rst;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  modport master (
    output locked, btn,
    input  periph_rst, core_rst, ready, lock_loss_cnt
  );

  modport slave (
    input  locked, btn,
    output periph_rst, core_rst, ready, lock_loss_cnt
  );
endinterface

// File: rtl/rst_seq.sv
// Staged reset sequencer: waits for a stable clock lock, releases peripherals,
// then the core, and falls back into reset on lock loss or a debounced button press.
module rst_seq #(
  parameter int TB_MODE         = 0,
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 1024,
  parameter int CORE_DELAY      = 16,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  rst_seq_if.slave   bus
);

  localparam int SYNC_N  = (TB_MODE != 0) ? 2 : SYNC_STAGES;
  localparam int HOLD_N  = (TB_MODE != 0) ? 4 : HOLD_CYCLES;
  localparam int CORE_N  = (TB_MODE != 0) ? 4 : CORE_DELAY;
  localparam int DEB_N   = (TB_MODE != 0) ? 4 : DEBOUNCE_CYCLES;
  localparam int SEQ_MAX = (HOLD_N > CORE_N) ? HOLD_N : CORE_N;
  localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
  localparam int DB_W    = (DEB_N > 1) ? $clog2(DEB_N) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    HOLD       = 2'd1,
    REL_PERIPH = 2'd2,
    RUN        = 2'd3
  } state_t;

  logic [SYNC_N-1:0] locked_sync_q, locked_sync_d;
  logic [SYNC_N-1:0] btn_sync_q, btn_sync_d;
  logic              btn_db_q, btn_db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  state_t            state_q, state_d;
  logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d;
  logic [7:0]        lock_loss_q, lock_loss_d;
  logic              periph_rst_q, periph_rst_d;
  logic              core_rst_q, core_rst_d;
  logic              ready_q, ready_d;

  logic locked_s;
  logic btn_s;
  logic abort;

  assign locked_s = locked_sync_q[SYNC_N-1];
  assign btn_s    = btn_sync_q[SYNC_N-1];
  assign abort    = !locked_s || btn_db_q;

  always_comb begin
    locked_sync_d = {locked_sync_q[SYNC_N-2:0], bus.locked};
    btn_sync_d    = {btn_sync_q[SYNC_N-2:0], bus.btn};
  end

  // A new button level is accepted only after DEB_N consecutive differing cycles.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == DB_W'(DEB_N - 1)) begin
        btn_db_d = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    seq_cnt_d   = seq_cnt_q + 1'b1;
    lock_loss_d = lock_loss_q;
    if (abort) begin
      state_d   = WAIT_LOCK;
      seq_cnt_d = '0;
      if (state_q == RUN && !locked_s && lock_loss_q != 8'hFF) begin
        lock_loss_d = lock_loss_q + 8'd1;
      end
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          state_d   = HOLD;
          seq_cnt_d = '0;
        end
        HOLD: begin
          if (seq_cnt_q == SEQ_W'(HOLD_N - 1)) begin
            state_d   = REL_PERIPH;
            seq_cnt_d = '0;
          end
        end
        REL_PERIPH: begin
          if (seq_cnt_q == SEQ_W'(CORE_N - 1)) begin
            state_d   = RUN;
            seq_cnt_d = '0;
          end
        end
        RUN: begin
          seq_cnt_d = '0;
        end
        default: begin
          state_d   = WAIT_LOCK;
          seq_cnt_d = '0;
        end
      endcase
    end
    // Decoding from the next state lets the registered resets move with the state.
    periph_rst_d = (state_d == WAIT_LOCK) || (state_d == HOLD);
    core_rst_d   = (state_d != RUN);
    ready_d      = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_sync_q <= '0;
      btn_sync_q    <= '0;
      btn_db_q      <= 1'b0;
      db_cnt_q      <= '0;
      state_q       <= WAIT_LOCK;
      seq_cnt_q     <= '0;
      lock_loss_q   <= 8'd0;
      periph_rst_q  <= 1'b1;
      core_rst_q    <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      locked_sync_q <= locked_sync_d;
      btn_sync_q    <= btn_sync_d;
      btn_db_q      <= btn_db_d;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      seq_cnt_q     <= seq_cnt_d;
      lock_loss_q   <= lock_loss_d;
      periph_rst_q  <= periph_rst_d;
      core_rst_q    <= core_rst_d;
      ready_q       <= ready_d;
    end
  end

  assign bus.periph_rst    = periph_rst_q;
  assign bus.core_rst      = core_rst_q;
  assign bus.ready         = ready_q;
  assign bus.lock_loss_cnt = lock_loss_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: random and directed lock/button stimulus, a cycle-level
// reference model feeding a scoreboard, plus directed latency checks.
module tb_rst_seq;

  localparam int SYNC = 2;
  localparam int HOLD = 8;
  localparam int CORE = 4;
  localparam int DEB  = 4;

  typedef struct packed {
    logic       periph;
    logic       core;
    logic       rdy;
    logic [7:0] cnt;
  } resp_t;

  logic clk = 1'b0;
  logic rst;

  rst_seq_if bus ();

  rst_seq #(
    .TB_MODE        (0),
    .SYNC_STAGES    (SYNC),
    .HOLD_CYCLES    (HOLD),
    .CORE_DELAY     (CORE),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int    tests_run    = 0;
  int    tests_failed = 0;
  resp_t exp_q[$];

  // Reference model: k counts consecutive edges without abort; the phase follows from k.
  bit lock_hist[$];
  bit btn_hist[$];
  bit m_db;
  int m_diff;
  int m_k;
  int m_cnt;

  initial begin : model
    bit    ls, bs, ab;
    resp_t r;
    forever begin
      @(posedge clk);
      if (rst) begin
        lock_hist = {};
        btn_hist  = {};
        for (int i = 0; i < SYNC; i++) begin
          lock_hist.push_back(1'b0);
          btn_hist.push_back(1'b0);
        end
        m_db   = 1'b0;
        m_diff = 0;
        m_k    = 0;
        m_cnt  = 0;
      end else begin
        ls = lock_hist.pop_front();
        bs = btn_hist.pop_front();
        lock_hist.push_back(bus.locked);
        btn_hist.push_back(bus.btn);
        ab = !ls || m_db;
        if (ab) begin
          if (m_k > HOLD + CORE && !ls && m_cnt < 255) m_cnt = m_cnt + 1;
          m_k = 0;
        end else if (m_k <= HOLD + CORE) begin
          m_k = m_k + 1;
        end
        if (bs == m_db) begin
          m_diff = 0;
        end else begin
          m_diff = m_diff + 1;
          if (m_diff == DEB) begin
            m_db   = bs;
            m_diff = 0;
          end
        end
      end
      r.periph = (m_k <= HOLD);
      r.core   = (m_k <= HOLD + CORE);
      r.rdy    = (m_k > HOLD + CORE);
      r.cnt    = m_cnt[7:0];
      exp_q.push_back(r);
    end
  end

  initial begin : monitor
    resp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.periph_rst, bus.core_rst, bus.ready, bus.lock_loss_cnt};
        tests_run = tests_run + 1;
        if (a !== e) begin
          tests_failed = tests_failed + 1;
          $display("[TB] FAIL scoreboard @%0t: got periph=%b core=%b ready=%b cnt=%0d, expected periph=%b core=%b ready=%b cnt=%0d",
                   $time, a.periph, a.core, a.rdy, a.cnt, e.periph, e.core, e.rdy, e.cnt);
        end
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run = tests_run + 1;
    if (actual !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic set_inputs(input logic lk, input logic b);
    @(negedge clk);
    bus.locked = lk;
    bus.btn    = b;
  endtask

  task automatic apply_stimulus(input logic lk, input logic b, input int n);
    set_inputs(lk, b);
    repeat (n) @(posedge clk);
  endtask

  // Edge index (1-based from the next edge) at which each reset first reads low.
  task automatic measure_release(input int max_edges, output int p_edge, output int c_edge);
    p_edge = -1;
    c_edge = -1;
    for (int e = 1; e <= max_edges; e++) begin
      @(posedge clk);
      #1;
      if (p_edge < 0 && bus.periph_rst === 1'b0) p_edge = e;
      if (c_edge < 0 && bus.core_rst === 1'b0) c_edge = e;
    end
  endtask

  task automatic measure_assert(input int max_edges, output int a_edge);
    a_edge = -1;
    for (int e = 1; e <= max_edges; e++) begin
      @(posedge clk);
      #1;
      if (a_edge < 0 && bus.periph_rst === 1'b1 && bus.core_rst === 1'b1 && bus.ready === 1'b0)
        a_edge = e;
    end
  endtask

  initial begin : stimulus
    int p, c, a;
    rst        = 1'b1;
    bus.locked = 1'b0;
    bus.btn    = 1'b0;
    repeat (3) @(posedge clk);

    @(negedge clk);
    rst        = 1'b0;
    bus.locked = 1'b1;
    measure_release(20, p, c);
    check_output("startup_periph_release_edge", p, 11);
    check_output("startup_core_release_edge", c, 15);
    check_output("startup_ready", int'(bus.ready), 1);
    check_output("startup_lock_loss", int'(bus.lock_loss_cnt), 0);

    set_inputs(1'b0, 1'b0);
    a = -1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      if (a < 0 && bus.periph_rst === 1'b1 && bus.core_rst === 1'b1 && bus.ready === 1'b0) a = e;
    end
    check_output("lock_drop_assert_edge", a, 3);
    set_inputs(1'b1, 1'b0);
    measure_release(20, p, c);
    check_output("relock_periph_release_edge", p, 11);
    check_output("relock_core_release_edge", c, 15);
    check_output("lock_loss_after_one_drop", int'(bus.lock_loss_cnt), 1);

    apply_stimulus(1'b0, 1'b0, 4);
    apply_stimulus(1'b1, 1'b0, 6);
    apply_stimulus(1'b0, 1'b0, 1);
    set_inputs(1'b1, 1'b0);
    measure_release(20, p, c);
    check_output("hold_restart_periph_release_edge", p, 11);
    check_output("hold_abort_lock_loss_unchanged", int'(bus.lock_loss_cnt), 2);

    for (int w = 1; w <= 3; w++) begin
      apply_stimulus(1'b1, 1'b1, w);
      apply_stimulus(1'b1, 1'b0, 6);
      check_output($sformatf("btn_bounce_%0d_ready", w), int'(bus.ready), 1);
    end
    set_inputs(1'b1, 1'b1);
    measure_assert(10, a);
    check_output("btn_assert_edge", a, 7);
    set_inputs(1'b1, 1'b0);
    measure_release(25, p, c);
    check_output("btn_release_periph_edge", p, 15);
    check_output("btn_release_core_edge", c, 19);
    check_output("btn_lock_loss_unchanged", int'(bus.lock_loss_cnt), 2);

    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'b0, 1'b0, 3);
      apply_stimulus(1'b1, 1'b0, 17);
    end
    check_output("lock_loss_saturated", int'(bus.lock_loss_cnt), 255);

    apply_stimulus(1'b0, 1'b0, 3);
    apply_stimulus(1'b1, 1'b0, 12);
    check_output("in_rel_periph_periph_rst", int'(bus.periph_rst), 0);
    check_output("in_rel_periph_core_rst", int'(bus.core_rst), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_mid_periph_rst", int'(bus.periph_rst), 1);
    check_output("rst_mid_core_rst", int'(bus.core_rst), 1);
    check_output("rst_mid_lock_loss", int'(bus.lock_loss_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    measure_release(20, p, c);
    check_output("after_rst_periph_release_edge", p, 11);
    check_output("after_rst_core_release_edge", c, 15);

    for (int i = 0; i < 400; i++) begin
      logic lk, b;
      int   n;
      lk = ($urandom_range(0, 9) != 0);
      b  = ($urandom_range(0, 14) == 0);
      n  = lk ? $urandom_range(1, 30) : $urandom_range(1, 4);
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      apply_stimulus(lk, b, n);
    end

    apply_stimulus(1'b1, 1'b0, 4);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
